// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch controller for the IF stage.
// Provides run / single-step / halt-on-opcode control for the debug unit.
module pc_fetch_ctrl #(
    parameter int               NBITS       = 32,
    parameter logic [NBITS-1:0] RESET_PC    = '0,
    parameter logic [NBITS-1:0] PC_INC      = NBITS'(4),
    parameter logic [31:0]      HALT_OPCODE = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_step,
    input  logic             step,
    input  logic             stall,
    input  logic [NBITS-1:0] pc_next,
    input  logic [31:0]      instr,
    output logic [NBITS-1:0] pc,
    output logic [NBITS-1:0] pc_plus4,
    output logic             pc_we,
    output logic             fetch_valid,
    output logic             halted,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t state_q, state_d;
    logic   step_pending, step_pending_d;
    logic   restart;
    logic   is_halt;

    assign is_halt     = (instr == HALT_OPCODE);
    assign pc_plus4    = pc + PC_INC;
    assign fetch_valid = pc_we;
    assign halted      = (state_q == HALT);
    assign state       = state_q;

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        step_pending_d = 1'b0;
        pc_we          = 1'b0;
        restart        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = mode_step ? STEP : RUN;
            end
            RUN: begin
                pc_we = !stall && !is_halt;
                if (!stall && is_halt) state_d = HALT;
            end
            STEP: begin
                pc_we = step_pending && !stall && !is_halt;
                // A pending step is consumed on the first unstalled cycle; a
                // fresh pulse in that same cycle re-arms it.
                step_pending_d = step || (step_pending && stall);
                if (step_pending && !stall && is_halt) state_d = HALT;
            end
            HALT: begin
                if (start) begin
                    state_d = IDLE;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_pending <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_pending <= step_pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (restart) begin
            pc <= RESET_PC;
        end else if (pc_we) begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the controller.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode_step, step, stall;
    logic [31:0] pc_next, instr;
    logic [31:0] pc, pc_plus4;
    logic        pc_we, fetch_valid, halted;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 stepping, 3 halted.
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_pend;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode_step   (mode_step),
        .step        (step),
        .stall       (stall),
        .pc_next     (pc_next),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_we       (pc_we),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_issue();
        bit go;
        go = (m_mode == 1) || (m_mode == 2 && m_pend);
        return go && !stall && (instr != HALT_WORD);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_pend = 1'b0;
    endtask

    task automatic model_advance();
        bit hit_halt;
        bit old_pend;
        hit_halt = (instr == HALT_WORD);
        old_pend = m_pend;
        m_pend   = 1'b0;
        case (m_mode)
            0: if (start) m_mode = mode_step ? 2 : 1;
            1: if (!stall) begin
                   if (hit_halt) m_mode = 3;
                   else m_pc = pc_next;
               end
            2: begin
                   if (old_pend && !stall) begin
                       if (hit_halt) m_mode = 3;
                       else m_pc = pc_next;
                   end
                   m_pend = step || (old_pend && stall);
               end
            default: if (start) begin
                   m_mode = 0;
                   m_pc   = 32'h0;
               end
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/pc"},          pc,                     m_pc);
        check({tag, "/pc_plus4"},    pc_plus4,               m_pc + 32'd4);
        check({tag, "/state"},       32'(state),             32'(m_mode));
        check({tag, "/halted"},      32'(halted),            32'(m_mode == 3));
        check({tag, "/pc_we"},       32'(pc_we),             32'(model_issue()));
        check({tag, "/fetch_valid"}, 32'(fetch_valid),       32'(model_issue()));
    endtask

    // Inputs are already driven; compare, then let one edge pass.
    task automatic cycle(input string tag);
        #1;
        compare_all(tag);
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode_step = 1'b0; step = 1'b0; stall = 1'b0;
        pc_next = 32'h0; instr = 32'h0000_0013;
        model_reset();

        // Reset held across an edge.
        @(posedge clk); #1;
        check("reset/pc", pc, 32'h0);
        check("reset/pc_plus4", pc_plus4, 32'h4);
        check("reset/state", 32'(state), 32'h0);
        check("reset/halted", 32'(halted), 32'h0);
        check("reset/pc_we", 32'(pc_we), 32'h0);
        rst_n = 1'b1;

        // Continuous run with sequential fetch.
        start = 1'b1; mode_step = 1'b0; pc_next = m_pc + 4;
        cycle("run_start");
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pc_next = m_pc + 4;
            cycle("run_seq");
        end
        check("run/pc_at_8", pc, 32'h8);

        // Two stalled cycles hold the PC, then a branch to 0x40.
        stall = 1'b1; pc_next = 32'h0000_00C0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("stall/pc_we", 32'(pc_we), 32'h0);
            cycle("stall");
            check("stall/pc_hold", pc, 32'h8);
        end
        stall = 1'b0; pc_next = 32'h40;
        cycle("branch");
        check("branch/pc", pc, 32'h40);

        // Jump to 0x10, where the HALT word sits.
        pc_next = 32'h10;
        cycle("to_halt_addr");
        instr = HALT_WORD; pc_next = 32'h14;
        cycle("halt_fetch");
        check("halt/state", 32'(state), 32'h3);
        check("halt/halted", 32'(halted), 32'h1);
        check("halt/pc", pc, 32'h10);
        cycle("halt_hold");
        instr = 32'h0000_0013; start = 1'b1;
        cycle("restart");
        start = 1'b0;
        check("restart/state", 32'(state), 32'h0);
        check("restart/pc", pc, 32'h0);
        check("restart/halted", 32'(halted), 32'h0);

        // Step mode: a pulse during a stall waits for the stall to lift.
        start = 1'b1; mode_step = 1'b1;
        cycle("step_start");
        start = 1'b0; stall = 1'b1; step = 1'b1; pc_next = 32'h4;
        cycle("step_in_stall");
        step = 1'b0;
        cycle("step_stall_hold");
        check("step_stall/pc", pc, 32'h0);
        stall = 1'b0;
        cycle("step_release");
        check("step_release/pc", pc, 32'h4);
        pc_next = 32'h8;
        cycle("step_idle");
        check("step_idle/pc", pc, 32'h4);

        // Back-to-back pulses while pending coalesce into one advance.
        stall = 1'b1; step = 1'b1;
        cycle("step_pair_a");
        cycle("step_pair_b");
        stall = 1'b0; step = 1'b0;
        cycle("step_pair_go");
        cycle("step_pair_after");
        check("step_pair/pc", pc, 32'h8);

        // Wrap-around of the sequential address.
        step = 1'b1; pc_next = 32'hFFFF_FFFC;
        cycle("wrap_arm");
        step = 1'b0;
        cycle("wrap_load");
        check("wrap/pc", pc, 32'hFFFF_FFFC);
        check("wrap/pc_plus4", pc_plus4, 32'h0);
        step = 1'b1;
        cycle("wrap_arm2");
        step = 1'b0; pc_next = m_pc + 4;
        cycle("wrap_go");
        check("wrap/pc_next0", pc, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom % 8) == 0;
            mode_step = $urandom % 2;
            step      = ($urandom % 3) == 0;
            stall     = ($urandom % 4) == 0;
            instr     = (($urandom % 10) == 0) ? HALT_WORD : $urandom;
            pc_next   = (($urandom % 4) == 0) ? {$urandom, 2'b00} : m_pc + 4;
            cycle("rand");
        end

        // Asynchronous reset mid-run takes effect before any clock edge.
        start = 1'b1; mode_step = 1'b0; stall = 1'b0; instr = 32'h0000_0013;
        pc_next = 32'h100;
        cycle("pre_async");
        start = 1'b0;
        cycle("pre_async2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async/pc", pc, 32'h0);
        check("async/state", 32'(state), 32'h0);
        check("async/pc_we", 32'(pc_we), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("post_async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
